// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: central stall/flush controller for a 5-stage pipeline
// (IF/ID, ID/EX, EX/MEM, MEM/WB pipeline registers).
//
// Decides each cycle, in priority order:
//   1. data-memory wait: freeze the whole pipe and bubble MEM/WB
//   2. taken branch in EX: flush IF/ID and ID/EX, keep fetching
//   3. load-use (plus RAW without forwarding): hold PC and IF/ID and
//      inject a bubble into ID/EX
// It also keeps a saturating stall counter and a sticky memory-timeout flag.
//
// Build option:
//   FORWARD_EN  defined   -> EX has a forwarding path; only load-use stalls.
//               undefined -> additional RAW stalls against EX and MEM writers.
//
// Ports:
//   clk_i, rst_ni           clock (rising edge), async active-low reset
//   id_rs_i, id_rt_i        source fields of the instruction in ID
//   id_uses_rt_i            ID instruction really reads rt
//   ex_memread_i            instruction in EX is a load
//   ex_regwrite_i, ex_rd_i  EX writer and its destination
//   mem_regwrite_i, mem_rd_i MEM writer and its destination
//   mem_access_i            MEM instruction is load/store
//   dmem_ready_i            data memory completes the access this cycle
//   branch_taken_i          branch resolved taken in EX
//   pc_en_o, ifid_en_o      PC / IF/ID load enables
//   ifid_flush_o            IF/ID loads a NOP
//   idex_flush_o            ID/EX loads a bubble
//   exmem_en_o              EX/MEM capture enable
//   memwb_bubble_o          MEM/WB captures WB control = 2'b00
//   stall_cnt_o             cycles with pc_en_o low since reset (saturating)
//   mem_timeout_o           sticky: a memory wait reached MAX_WAIT cycles
//   state_o                 debug view of the FSM (0 = RUN, 1 = MEM_WAIT)
//
// Handshake: dmem_ready_i is only meaningful while mem_access_i is high; an
// access completes on a cycle where both are high, and every cycle where
// mem_access_i is high and dmem_ready_i is low is one wait state.

module pipe_hazard_ctrl #(
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [4:0]       id_rs_i,
  input  logic [4:0]       id_rt_i,
  input  logic             id_uses_rt_i,
  input  logic             ex_memread_i,
  input  logic             ex_regwrite_i,
  input  logic [4:0]       ex_rd_i,
  input  logic             mem_regwrite_i,
  input  logic [4:0]       mem_rd_i,
  input  logic             mem_access_i,
  input  logic             dmem_ready_i,
  input  logic             branch_taken_i,
  output logic             pc_en_o,
  output logic             ifid_en_o,
  output logic             ifid_flush_o,
  output logic             idex_flush_o,
  output logic             exmem_en_o,
  output logic             memwb_bubble_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic             mem_timeout_o,
  output logic             state_o
);

  typedef enum logic [0:0] {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_e;

  localparam int WC_W = $clog2(MAX_WAIT + 1);

  state_e            state_q, state_d;
  logic [WC_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic              mem_timeout_q, mem_timeout_d;

  logic mem_wait;
  logic load_use;
  logic raw_hazard;
  logic hazard;

  // Register 0 is hard-wired, so a match against rd == 0 is never a hazard.
  function automatic logic src_match(input logic [4:0] rd,
                                     input logic [4:0] rs,
                                     input logic [4:0] rt,
                                     input logic       uses_rt);
    return (rd != 5'd0) && ((rd == rs) || (uses_rt && (rd == rt)));
  endfunction

  always_comb begin
    mem_wait = mem_access_i && !dmem_ready_i;
    load_use = ex_memread_i && src_match(ex_rd_i, id_rs_i, id_rt_i, id_uses_rt_i);
  end

`ifdef FORWARD_EN
  // Forwarding covers EX/MEM producers; only the load result is too late.
  assign raw_hazard = 1'b0;
  logic unused_fwd;
  assign unused_fwd = ^{ex_regwrite_i, mem_regwrite_i, mem_rd_i};
`else
  // No forwarding: any in-flight producer in EX or MEM must retire first.
  // WB-stage producers are covered by write-before-read in the register file.
  assign raw_hazard =
      (ex_regwrite_i  && src_match(ex_rd_i,  id_rs_i, id_rt_i, id_uses_rt_i)) ||
      (mem_regwrite_i && src_match(mem_rd_i, id_rs_i, id_rt_i, id_uses_rt_i));
`endif

  assign hazard = load_use || raw_hazard;

  // Control outputs: purely combinational from reset, state inputs and hazards.
  always_comb begin
    pc_en_o        = 1'b1;
    ifid_en_o      = 1'b1;
    ifid_flush_o   = 1'b0;
    idex_flush_o   = 1'b0;
    exmem_en_o     = 1'b1;
    memwb_bubble_o = 1'b0;
    if (!rst_ni) begin
      pc_en_o        = 1'b0;
      ifid_en_o      = 1'b0;
      exmem_en_o     = 1'b0;
      ifid_flush_o   = 1'b1;
      idex_flush_o   = 1'b1;
      memwb_bubble_o = 1'b1;
    end else if (mem_wait) begin
      // Whole pipe frozen; a branch in EX stays in EX and is taken after release.
      pc_en_o        = 1'b0;
      ifid_en_o      = 1'b0;
      exmem_en_o     = 1'b0;
      memwb_bubble_o = 1'b1;
    end else if (branch_taken_i) begin
      // The ID instruction is discarded anyway, so it cannot cause a stall.
      ifid_flush_o = 1'b1;
      idex_flush_o = 1'b1;
    end else if (hazard) begin
      pc_en_o      = 1'b0;
      ifid_en_o    = 1'b0;
      idex_flush_o = 1'b1;
    end
  end

  // Next-state logic. Outputs do not depend on the state itself: a release
  // cycle behaves like any RUN cycle, so the state is a record of the wait.
  always_comb begin
    state_d       = RUN;
    wait_cnt_d    = '0;
    mem_timeout_d = mem_timeout_q;
    stall_cnt_d   = stall_cnt_q;

    if (mem_wait) begin
      state_d    = MEM_WAIT;
      wait_cnt_d = wait_cnt_q;
      if (int'(wait_cnt_q) < MAX_WAIT) begin
        wait_cnt_d = wait_cnt_q + 1'b1;
      end
      if (int'(wait_cnt_q) + 1 >= MAX_WAIT) begin
        mem_timeout_d = 1'b1;
      end
    end

    if (!pc_en_o && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= RUN;
      wait_cnt_q    <= '0;
      stall_cnt_q   <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      stall_cnt_q   <= stall_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  assign stall_cnt_o   = stall_cnt_q;
  assign mem_timeout_o = mem_timeout_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed testbench for pipe_hazard_ctrl with a rule-level reference model.
module tb_pipe_hazard_ctrl;

  localparam int MAX_WAIT = 4;
  localparam int CNT_W    = 4;
  localparam int SAT      = (1 << CNT_W) - 1;
  localparam int W        = 2 + CNT_W + 6;

`ifdef FORWARD_EN
  localparam bit NO_FWD = 1'b0;
`else
  localparam bit NO_FWD = 1'b1;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [4:0] id_rs, id_rt, ex_rd, mem_rd;
  logic id_uses_rt, ex_memread, ex_regwrite, mem_regwrite;
  logic mem_access, dmem_ready, branch_taken;
  logic pc_en, ifid_en, ifid_flush, idex_flush, exmem_en, memwb_bubble;
  logic [CNT_W-1:0] stall_cnt;
  logic mem_timeout, state;

  pipe_hazard_ctrl #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .id_rs_i(id_rs), .id_rt_i(id_rt), .id_uses_rt_i(id_uses_rt),
    .ex_memread_i(ex_memread), .ex_regwrite_i(ex_regwrite), .ex_rd_i(ex_rd),
    .mem_regwrite_i(mem_regwrite), .mem_rd_i(mem_rd),
    .mem_access_i(mem_access), .dmem_ready_i(dmem_ready),
    .branch_taken_i(branch_taken),
    .pc_en_o(pc_en), .ifid_en_o(ifid_en), .ifid_flush_o(ifid_flush),
    .idex_flush_o(idex_flush), .exmem_en_o(exmem_en),
    .memwb_bubble_o(memwb_bubble), .stall_cnt_o(stall_cnt),
    .mem_timeout_o(mem_timeout), .state_o(state)
  );

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  // ---------------- reference model ----------------
  int m_stall, m_wait;
  bit m_tmo, m_state;

  function automatic bit reads(input logic [4:0] rd);
    return (rd != 0) && (rd == id_rs || (id_uses_rt && rd == id_rt));
  endfunction

  // {pc_en, ifid_en, ifid_flush, idex_flush, exmem_en, memwb_bubble}
  function automatic logic [5:0] exp_ctrl();
    bit stall;
    if (!rst_n) return 6'b00_11_01;
    if (mem_access && !dmem_ready) return 6'b00_00_01;
    if (branch_taken) return 6'b11_11_10;
    stall = ex_memread && reads(ex_rd);
    if (NO_FWD) stall = stall || (ex_regwrite && reads(ex_rd)) || (mem_regwrite && reads(mem_rd));
    if (stall) return 6'b00_01_10;
    return 6'b11_00_10;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_stall = 0; m_wait = 0; m_tmo = 0; m_state = 0;
    end else begin
      if (exp_ctrl() >> 5 == 0) m_stall = (m_stall >= SAT) ? SAT : m_stall + 1;
      if (mem_access && !dmem_ready) begin
        m_wait = m_wait + 1;
        if (m_wait >= MAX_WAIT) m_tmo = 1;
        m_state = 1;
      end else begin
        m_wait = 0;
        m_state = 0;
      end
    end
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];

  always @(negedge clk) begin
    logic [W-1:0] e, a;
    #1;
    if (chk_en) exp_q.push_back({m_state, m_tmo, m_stall[CNT_W-1:0], exp_ctrl()});
    #1;
    if (chk_en && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {state, mem_timeout, stall_cnt, pc_en, ifid_en, ifid_flush, idex_flush, exmem_en, memwb_bubble};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL cycle_model @%0t: got %h expected %h", $time, a, e);
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle();
    id_rs = 5'd1; id_rt = 5'd2; id_uses_rt = 1'b0;
    ex_memread = 1'b0; ex_regwrite = 1'b0; ex_rd = 5'd0;
    mem_regwrite = 1'b0; mem_rd = 5'd0;
    mem_access = 1'b0; dmem_ready = 1'b1; branch_taken = 1'b0;
  endtask

  task automatic nc();
    @(negedge clk);
    idle();
  endtask

  task automatic reset_dut();
    @(negedge clk);
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    idle();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    chk_en = 1'b1;
    #2;
    check("rst_pc_en", pc_en, 0);
    check("rst_exmem_en", exmem_en, 0);
    check("rst_flushes", {ifid_flush, idex_flush, memwb_bubble}, 3'b111);
    check("rst_stall_cnt", stall_cnt, 0);
    check("rst_timeout", mem_timeout, 0);
    @(negedge clk) rst_n = 1'b1;
    #3 check("post_rst_pc_en", pc_en, 1);

    // load-use: one stall cycle
    nc(); ex_memread = 1; ex_regwrite = 1; ex_rd = 5'd5; id_rs = 5'd5;
    #3 check("lu_ctrl", {pc_en, ifid_en, idex_flush, exmem_en, ifid_flush}, 5'b00110);
    nc();
    #3 check("lu_release_pc_en", pc_en, 1);
    check("lu_stall_cnt", stall_cnt, 1);

    // rd zero never hazards
    nc(); ex_memread = 1; ex_regwrite = 1; ex_rd = 5'd0; id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1;
    #3 check("rd0_pc_en", pc_en, 1);
    nc();
    #3 check("rd0_stall_cnt", stall_cnt, 1);

    // memory wait 3 cycles, branch ignored in the middle
    reset_dut();
    for (int i = 0; i < 3; i++) begin
      nc(); mem_access = 1; dmem_ready = 0; branch_taken = (i == 1);
      #3 check("mw_ctrl", {pc_en, ifid_en, exmem_en, memwb_bubble, ifid_flush, idex_flush}, 6'b000100);
    end
    nc(); mem_access = 1; dmem_ready = 1;
    #3 check("mw_state_wait", state, 1);
    check("mw_release_pc_en", {pc_en, memwb_bubble}, 2'b10);
    nc();
    #3 check("mw_state_run", state, 0);
    check("mw_stall_cnt", stall_cnt, 3);

    // timeout after MAX_WAIT wait cycles, sticky
    reset_dut();
    for (int i = 0; i < 6; i++) begin
      nc(); mem_access = 1; dmem_ready = 0;
      #3 check("tmo_progress", mem_timeout, (i >= MAX_WAIT) ? 1 : 0);
    end
    nc(); mem_access = 1; dmem_ready = 1;
    #3 check("tmo_after_last_wait", mem_timeout, 1);
    nc();
    #3 check("tmo_sticky", mem_timeout, 1);
    check("tmo_stall_cnt", stall_cnt, 6);

    // branch overrides load-use
    reset_dut();
    nc(); branch_taken = 1; ex_memread = 1; ex_regwrite = 1; ex_rd = 5'd5; id_rs = 5'd5;
    #3 check("br_ctrl", {pc_en, ifid_en, ifid_flush, idex_flush, exmem_en, memwb_bubble}, 6'b111110);
    nc();
    #3 check("br_stall_cnt", stall_cnt, 0);

    // RAW against MEM through rt
    nc(); mem_regwrite = 1; mem_rd = 5'd7; id_rt = 5'd7; id_uses_rt = 1;
    #3 check("raw_mem_pc_en", pc_en, NO_FWD ? 0 : 1);
    nc(); mem_regwrite = 1; mem_rd = 5'd7; id_rt = 5'd7; id_uses_rt = 0;
    #3 check("raw_rt_unused_pc_en", pc_en, 1);
    // RAW against EX through rs
    nc(); ex_regwrite = 1; ex_rd = 5'd3; id_rs = 5'd3;
    #3 check("raw_ex_pc_en", pc_en, NO_FWD ? 0 : 1);
    nc();
    #3 check("raw_stall_cnt", stall_cnt, NO_FWD ? 2 : 0);

    // asynchronous reset in the middle of a wait
    reset_dut();
    for (int i = 0; i < 5; i++) begin
      nc(); mem_access = 1; dmem_ready = 0;
    end
    #3 check("pre_rst_timeout", mem_timeout, 1);
    rst_n = 1'b0;
    #1 check("midrst_state", state, 0);
    check("midrst_counters", {stall_cnt, mem_timeout}, 0);
    check("midrst_ctrl", {pc_en, idex_flush}, 2'b01);
    @(negedge clk); idle(); rst_n = 1'b1;
    #3 check("midrst_release_pc_en", pc_en, 1);

    // stall counter saturates
    for (int i = 0; i < 20; i++) begin
      nc(); mem_access = 1; dmem_ready = 0;
    end
    nc();
    #3 check("stall_cnt_sat", stall_cnt, SAT);

    @(negedge clk);
    chk_en = 1'b0;
    #5;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
